// File: rtl/vga_pkg.sv
// Shared VGA constants and the pixel-unpacker state encoding.
// Widths here are defaults only; instantiating modules may override them.
package vga_pkg;

  localparam int MM_MEM_DATA_WIDTH = 32;
  localparam int FB_PIXEL_WIDTH    = 8;
  localparam int WIDTH             = 640;
  localparam int HEIGHT            = 480;
  localparam int UNDERFLOW_COLOR   = 0;

  typedef enum logic [1:0] {
    SEEK_SOP   = 2'd0,
    WAIT_FRAME = 2'd1,
    STREAM     = 2'd2
  } vga_unpack_state_t;

endpackage

// File: rtl/vga_pixel_unpacker.sv
// Unpacks Avalon-ST words into pixels (LSB first); pix_data/pix_valid follow pix_req by one cycle.
// One-word hold register: st_ready only while the hold is empty or its last pixel is consumed in STREAM.
module vga_pixel_unpacker #(
  parameter int MM_DATA_WIDTH  = vga_pkg::MM_MEM_DATA_WIDTH,
  parameter int FB_PIXEL_WIDTH = vga_pkg::FB_PIXEL_WIDTH,
  parameter int FRAME_PIXELS   = vga_pkg::WIDTH * vga_pkg::HEIGHT
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    st_valid,
  input  logic [MM_DATA_WIDTH-1:0]                st_data,
  input  logic                                    st_startofpacket,
  input  logic                                    st_endofpacket,
  input  logic [$clog2(MM_DATA_WIDTH/8+1)-1:0]    st_empty,
  output logic                                    st_ready,
  input  logic                                    pix_frame_start,
  input  logic                                    pix_req,
  output logic [FB_PIXEL_WIDTH-1:0]               pix_data,
  output logic                                    pix_valid,
  input  logic                                    clear_status,
  output logic                                    status_underflow,
  output logic                                    status_frame_error
);
  import vga_pkg::*;

  localparam int PPW   = MM_DATA_WIDTH / FB_PIXEL_WIDTH;
  localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam logic [FB_PIXEL_WIDTH-1:0] UF_PIX = FB_PIXEL_WIDTH'(UNDERFLOW_COLOR);

  generate
    if (PPW < 1 || (MM_DATA_WIDTH % FB_PIXEL_WIDTH) != 0) begin : g_bad_ppw
      $error("vga_pixel_unpacker: MM_DATA_WIDTH must be a whole multiple of FB_PIXEL_WIDTH");
    end
  endgenerate

  vga_unpack_state_t                  r_state;
  logic [PPW-1:0][FB_PIXEL_WIDTH-1:0] r_hold;
  logic                               r_hold_full;
  logic                               r_hold_eop;
  logic [IDX_W-1:0]                   r_idx;
  logic [CNT_W-1:0]                   r_cnt;
  logic [FB_PIXEL_WIDTH-1:0]          r_pix_data;
  logic                               r_pix_valid;
  logic                               r_underflow;
  logic                               r_frame_err;

  logic             w_last_idx;
  logic             w_emit;
  logic             w_frame_done;
  logic             w_take;
  logic             w_underflow;
  logic             w_fs_err;
  logic             w_abort_load;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_unused_empty;

  assign w_unused_empty = ^st_empty;

  assign w_last_idx   = (r_idx == IDX_W'(PPW - 1));
  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_frame_done = (w_cnt_inc == CNT_W'(FRAME_PIXELS));
  assign w_emit       = pix_req &&
                        ((r_state == STREAM && !pix_frame_start && r_hold_full) ||
                         (r_state == WAIT_FRAME && pix_frame_start));
  assign w_underflow  = (r_state == STREAM) && pix_req && !pix_frame_start && !r_hold_full;
  assign w_fs_err     = (r_state == STREAM) && pix_frame_start;
  // A plain data beat is only useful if the frame is still running after this cycle.
  assign w_abort_load = w_fs_err || w_underflow || (w_emit && w_frame_done);

  // Hold is always empty in SEEK_SOP and always full in WAIT_FRAME.
  assign st_ready = reset_n &&
                    (!r_hold_full || (r_state == STREAM && w_emit && w_last_idx));
  assign w_take   = st_valid && st_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SEEK_SOP;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_hold_eop  <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_underflow <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_pix_valid <= pix_req;
      r_pix_data  <= UF_PIX;

      if (clear_status) begin
        r_underflow <= 1'b0;
        r_frame_err <= 1'b0;
      end

      if (w_emit) begin
        r_pix_data <= r_hold[r_idx];
        r_idx      <= w_last_idx ? '0 : r_idx + IDX_W'(1);
        r_cnt      <= w_cnt_inc;
        r_state    <= STREAM;
        if (w_last_idx) r_hold_full <= 1'b0;
        if (w_frame_done) begin
          if (!(w_last_idx && r_hold_eop)) r_frame_err <= 1'b1;
          r_state     <= SEEK_SOP;
          r_hold_full <= 1'b0;
          r_idx       <= '0;
          r_cnt       <= '0;
        end
      end

      if (w_fs_err || w_underflow) begin
        if (w_fs_err) r_frame_err <= 1'b1;
        else          r_underflow <= 1'b1;
        r_state     <= SEEK_SOP;
        r_hold_full <= 1'b0;
        r_idx       <= '0;
        r_cnt       <= '0;
      end

      // A start-of-packet beat always restarts framing, even mid-stream.
      if (w_take) begin
        if (st_startofpacket) begin
          if (r_state == STREAM && !(w_emit && w_frame_done)) r_frame_err <= 1'b1;
          r_hold      <= st_data;
          r_hold_full <= 1'b1;
          r_hold_eop  <= st_endofpacket;
          r_idx       <= '0;
          r_cnt       <= '0;
          r_state     <= WAIT_FRAME;
        end else if (r_state == STREAM && !w_abort_load) begin
          r_hold      <= st_data;
          r_hold_full <= 1'b1;
          r_hold_eop  <= st_endofpacket;
        end
      end
    end
  end

  assign pix_data           = r_pix_data;
  assign pix_valid          = r_pix_valid;
  assign status_underflow   = r_underflow;
  assign status_frame_error = r_frame_err;

endmodule

// File: doc/vga_pixel_unpacker.md
VGA_PIXEL_UNPACKER -- requirements
Module: vga_pixel_unpacker

Interface
REQ-001 Parameter MM_DATA_WIDTH, default MM_MEM_DATA_WIDTH, is the stream word width in bits.
REQ-002 Parameter FB_PIXEL_WIDTH, default FB_PIXEL_WIDTH from vga_pkg, is the pixel width in bits.
REQ-003 Parameter FRAME_PIXELS, default WIDTH*HEIGHT, is the number of pixels per frame.
REQ-004 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 st_valid, st_data[MM_DATA_WIDTH], st_startofpacket, st_endofpacket, st_empty[$clog2(MM_DATA_WIDTH/8+1)]  in  Avalon ST sink; st_empty SHALL be ignored.
REQ-007 st_ready  out  1  sink ready; a beat transfers when st_valid and st_ready are both high (ready latency 0).
REQ-008 pix_frame_start  in  1  one-cycle pulse from VGA timing, coincident with the first pix_req of a frame.
REQ-009 pix_req  in  1  the timing block consumes one pixel this cycle.
REQ-010 pix_data  out  FB_PIXEL_WIDTH  registered pixel value.
REQ-011 pix_valid  out  1  high one cycle after each pix_req.
REQ-012 clear_status  in  1  clears the sticky status flags.
REQ-013 status_underflow, status_frame_error  out  1 each  sticky error flags.

Function
REQ-014 PPW = MM_DATA_WIDTH/FB_PIXEL_WIDTH SHALL be an integer of at least 1; a violation SHALL be an elaboration error.
REQ-015 Pixels SHALL be unpacked from each word least-significant pixel first.
REQ-016 The word holding register SHALL be one deep; st_ready = hold empty, or (last pixel index of the word consumed this cycle and state STREAM).
REQ-017 The FSM SHALL have states SEEK_SOP, WAIT_FRAME, STREAM, and reset SHALL enter SEEK_SOP.
REQ-018 SEEK_SOP: st_ready=1; beats without startofpacket SHALL be discarded; a startofpacket beat SHALL be loaded into hold, then go to WAIT_FRAME.
REQ-019 WAIT_FRAME: st_ready=0; on pix_frame_start with pix_req, go to STREAM and emit pixel 0 of hold.
REQ-020 STREAM: each pix_req SHALL emit the next pixel, advance the pixel index (wrapping at PPW) and increment the frame pixel counter.
REQ-021 Latency: pix_data/pix_valid SHALL follow pix_req by exactly one cycle.
REQ-022 Underflow: pix_req in STREAM with hold empty SHALL output UNDERFLOW_COLOR, set status_underflow, and go to SEEK_SOP.
REQ-023 A startofpacket beat accepted in STREAM before FRAME_PIXELS pixels are emitted SHALL set status_frame_error; that beat SHALL be loaded into hold, then go to WAIT_FRAME.
REQ-024 When the frame pixel counter reaches FRAME_PIXELS, the word just exhausted SHALL have carried endofpacket; otherwise status_frame_error SHALL be set; in both cases go to SEEK_SOP.
REQ-025 pix_frame_start in STREAM SHALL set status_frame_error, output UNDERFLOW_COLOR for that request, and go to SEEK_SOP.
REQ-026 pix_req in SEEK_SOP, or in WAIT_FRAME without pix_frame_start, SHALL output UNDERFLOW_COLOR with pix_valid=1, and SHALL NOT set any flag.
REQ-027 clear_status SHALL clear the flags; a set event in the same cycle SHALL win.
REQ-028 The frame pixel counter width SHALL be $clog2(FRAME_PIXELS+1), with no wrap before the end-of-frame check.

Reset
REQ-029 While reset_n=0: state SEEK_SOP, hold empty, counters 0, st_ready=0, pix_valid=0, pix_data=0, status flags 0.
REQ-030 Reset deassertion mid-frame SHALL restart from SEEK_SOP; no partial word SHALL be retained.

Structure
REQ-031 vga_pkg SHALL hold UNDERFLOW_COLOR (default 0) and the state enum vga_unpack_state_t.
REQ-032 PPW and the counter widths SHALL be module localparams.
REQ-033 The block SHALL be a single module with no sub-modules; it connects directly to the Avalon ST output of vga_frame_buffer_stream.

Verification (MM_DATA_WIDTH=32, FB_PIXEL_WIDTH=8, FRAME_PIXELS=16)
REQ-034 Four words 0x03020100..0x0F0E0D0C (SOP on the first, EOP on the last), frame_start, 16 back-to-back pix_req -> pix_data 0x00..0x0F, each one cycle after its request, flags 0.
REQ-035 Two garbage beats, then the SOP frame -> garbage dropped, output identical to REQ-034.
REQ-036 st_valid withheld after word 2 while pix_req continues -> pixels 0..7 correct, pixel 8 = 0x00, status_underflow=1, state SEEK_SOP.
REQ-037 SOP arrives at word 3 -> status_frame_error=1, new frame waits for the next frame_start; EOP missing on word 4 -> status_frame_error=1.
REQ-038 reset_n pulsed low after pixel 5 -> all outputs at their reset values; the next SOP frame streams correctly.
REQ-039 clear_status asserted together with a new underflow -> status_underflow stays 1; the next clear_status alone clears it.
